mult_accum: RTL and testbench

Frame accumulator placed directly downstream of the shift-add pipelined multiplier. It takes the multiplier's product stream (`dout`/`valid`) and sums FRAME_LEN consecutive products into one unsigned result. The result is held in an output register and offered to the next stage through a valid/ready handshake. The multiplier cannot be stalled, so this block never back-pressures its input; a result that cannot be delivered in time is reported on a sticky overrun flag.

---
 rtl/mult_accum.sv | 98 +++++++++
 tb/tb_mult_accum.sv | 198 +++++++++++++++++++
 2 files changed

// File: rtl/mult_accum.sv
// Frame accumulator for a non-stallable product stream: sums FRAME_LEN products
// per frame and offers each sum on a valid/ready output register.
module mult_accum #(
  parameter int PROD_W    = 16,
  parameter int FRAME_LEN = 8,
  parameter int ACC_W     = 19
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clr,
  input  logic              din_valid,
  input  logic [PROD_W-1:0] din,
  output logic [ACC_W-1:0]  acc_out,
  output logic              acc_valid,
  input  logic              acc_ready,
  output logic              overrun,
  output logic              busy
);

  localparam int CNT_W = (FRAME_LEN > 1) ? $clog2(FRAME_LEN) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(FRAME_LEN - 1);

  logic [ACC_W-1:0] acc_q, acc_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [ACC_W-1:0] acc_out_q, acc_out_d;
  logic             acc_valid_q, acc_valid_d;
  logic             overrun_q, overrun_d;
  logic             busy_q, busy_d;

  logic [ACC_W-1:0] sum;
  logic             frame_last;
  logic             xfer;
  logic             can_load;

  // Output handshake: a result moves downstream on any rising edge where
  // acc_valid and acc_ready are both 1; acc_out is held while acc_valid=1 and
  // acc_ready=0. The input side has no ready: every din_valid beat is consumed.
  assign sum        = acc_q + ACC_W'(din);
  assign frame_last = (cnt_q == CNT_LAST);
  assign xfer       = acc_valid_q && acc_ready;
  assign can_load   = !acc_valid_q || acc_ready;

  always_comb begin
    acc_d       = acc_q;
    cnt_d       = cnt_q;
    acc_out_d   = acc_out_q;
    acc_valid_d = acc_valid_q;
    overrun_d   = overrun_q;
    if (xfer) begin
      acc_valid_d = 1'b0;
    end
    if (clr) begin
      acc_d     = '0;
      cnt_d     = '0;
      overrun_d = 1'b0;
    end else if (din_valid) begin
      if (frame_last) begin
        // Restart the frame in the same cycle so back-to-back frames have no bubble.
        acc_d = '0;
        cnt_d = '0;
        if (can_load) begin
          acc_out_d   = sum;
          acc_valid_d = 1'b1;
        end else begin
          overrun_d = 1'b1;
        end
      end else begin
        acc_d = sum;
        cnt_d = cnt_q + CNT_W'(1);
      end
    end
    busy_d = (cnt_d != '0);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      acc_q       <= '0;
      cnt_q       <= '0;
      acc_out_q   <= '0;
      acc_valid_q <= 1'b0;
      overrun_q   <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      acc_q       <= acc_d;
      cnt_q       <= cnt_d;
      acc_out_q   <= acc_out_d;
      acc_valid_q <= acc_valid_d;
      overrun_q   <= overrun_d;
      busy_q      <= busy_d;
    end
  end

  assign acc_out   = acc_out_q;
  assign acc_valid = acc_valid_q;
  assign overrun   = overrun_q;
  assign busy      = busy_q;

endmodule

// File: tb/tb_mult_accum.sv
// Directed bench for mult_accum with PROD_W=16, FRAME_LEN=4, ACC_W=18.
module tb_mult_accum;

  localparam int PROD_W    = 16;
  localparam int FRAME_LEN = 4;
  localparam int ACC_W     = 18;

  logic              clk;
  logic              rst;
  logic              clr;
  logic              din_valid;
  logic [PROD_W-1:0] din;
  logic [ACC_W-1:0]  acc_out;
  logic              acc_valid;
  logic              acc_ready;
  logic              overrun;
  logic              busy;

  int checks;
  int failures;
  int busy_cycles;

  mult_accum #(
    .PROD_W(PROD_W),
    .FRAME_LEN(FRAME_LEN),
    .ACC_W(ACC_W)
  ) dut (
    .clk(clk),
    .rst(rst),
    .clr(clr),
    .din_valid(din_valid),
    .din(din),
    .acc_out(acc_out),
    .acc_valid(acc_valid),
    .acc_ready(acc_ready),
    .overrun(overrun),
    .busy(busy)
  );

  // clock
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // one rising edge; outputs are sampled 1ns after it
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [PROD_W-1:0] d);
    din_valid = 1'b1;
    din       = d;
    tick();
    din_valid = 1'b0;
    din       = '0;
  endtask

  task automatic idle();
    din_valid = 1'b0;
    tick();
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  initial begin
    checks    = 0;
    failures  = 0;
    rst       = 1'b1;
    clr       = 1'b0;
    din_valid = 1'b0;
    din       = '0;
    acc_ready = 1'b0;
    tick();
    tick();
    rst = 1'b0;

    check("rst_acc_out",   32'(acc_out), 32'd0);
    check("rst_acc_valid", 32'(acc_valid), 32'd0);
    check("rst_overrun",   32'(overrun), 32'd0);
    check("rst_busy",      32'(busy), 32'd0);

    // Basic frame 1,2,3,4 with ready held high
    acc_ready   = 1'b1;
    busy_cycles = 0;
    send(16'd1); busy_cycles += int'(busy);
    check("basic_valid_early", 32'(acc_valid), 32'd0);
    send(16'd2); busy_cycles += int'(busy);
    send(16'd3); busy_cycles += int'(busy);
    send(16'd4); busy_cycles += int'(busy);
    check("basic_valid", 32'(acc_valid), 32'd1);
    check("basic_out",   32'(acc_out), 32'd10);
    idle();      busy_cycles += int'(busy);
    check("basic_valid_pulse", 32'(acc_valid), 32'd0);
    check("basic_out_hold",    32'(acc_out), 32'd10);
    check("basic_busy_cycles", 32'(busy_cycles), 32'd3);

    // Max values with idle gaps
    do_reset();
    acc_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      send(16'hFFFF);
      idle();
      check("max_busy_gap", 32'(busy), 32'd1);
    end
    send(16'hFFFF);
    check("max_valid", 32'(acc_valid), 32'd1);
    check("max_out",   32'(acc_out), 32'd262140);
    check("max_busy_end", 32'(busy), 32'd0);

    // Back-to-back frames with stalled output
    do_reset();
    acc_ready = 1'b0;
    for (int i = 1; i <= 4; i++) send(16'(i));
    check("b2b_first_valid", 32'(acc_valid), 32'd1);
    check("b2b_first_out",   32'(acc_out), 32'd10);
    check("b2b_busy_restart", 32'(busy), 32'd0);
    for (int i = 5; i <= 7; i++) send(16'(i));
    check("b2b_no_overrun_yet", 32'(overrun), 32'd0);
    send(16'd8);
    check("b2b_overrun",   32'(overrun), 32'd1);
    check("b2b_out_kept",  32'(acc_out), 32'd10);
    check("b2b_valid_kept", 32'(acc_valid), 32'd1);
    acc_ready = 1'b1;
    idle();
    check("b2b_valid_fall",   32'(acc_valid), 32'd0);
    check("b2b_overrun_sticky", 32'(overrun), 32'd1);

    // Completion coinciding with a transfer
    do_reset();
    acc_ready = 1'b0;
    for (int i = 1; i <= 7; i++) send(16'(i));
    acc_ready = 1'b1;
    send(16'd8);
    check("coin_out",     32'(acc_out), 32'd26);
    check("coin_valid",   32'(acc_valid), 32'd1);
    check("coin_overrun", 32'(overrun), 32'd0);
    idle();
    check("coin_valid_fall", 32'(acc_valid), 32'd0);

    // clr mid-frame, with an overrun and a pending result present
    do_reset();
    acc_ready = 1'b0;
    for (int i = 0; i < 2; i++)
      for (int j = 1; j <= 4; j++) send(16'(j));
    check("clr_pre_overrun", 32'(overrun), 32'd1);
    send(16'd5);
    send(16'd5);
    clr = 1'b1;
    send(16'd9);
    clr = 1'b0;
    check("clr_busy",       32'(busy), 32'd0);
    check("clr_overrun",    32'(overrun), 32'd0);
    check("clr_valid_kept", 32'(acc_valid), 32'd1);
    check("clr_out_kept",   32'(acc_out), 32'd10);
    acc_ready = 1'b1;
    idle();
    check("clr_drained", 32'(acc_valid), 32'd0);
    for (int i = 0; i < 4; i++) send(16'd1);
    check("clr_result", 32'(acc_out), 32'd4);
    check("clr_result_valid", 32'(acc_valid), 32'd1);

    // Reset mid-frame with a pending result
    do_reset();
    acc_ready = 1'b0;
    for (int i = 1; i <= 4; i++) send(16'(i));
    send(16'd1);
    send(16'd1);
    check("rstmid_pre_valid", 32'(acc_valid), 32'd1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("rstmid_out",     32'(acc_out), 32'd0);
    check("rstmid_valid",   32'(acc_valid), 32'd0);
    check("rstmid_overrun", 32'(overrun), 32'd0);
    check("rstmid_busy",    32'(busy), 32'd0);
    for (int i = 0; i < 4; i++) send(16'd2);
    check("rstmid_result", 32'(acc_out), 32'd8);
    check("rstmid_result_valid", 32'(acc_valid), 32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
